// File: rtl/inst_fifo.sv
// Dual-issue instruction queue between fetch and decode.
// Accepts up to two {pc,inst} pairs per cycle and presents the oldest two
// entries first-word-fall-through. A flush empties the queue on redirect.
module inst_fifo #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               write_en1,
    input  logic               write_en2,
    input  logic [31:0]        write_pc1,
    input  logic [31:0]        write_inst1,
    input  logic [31:0]        write_pc2,
    input  logic [31:0]        write_inst2,
    input  logic               read_en1,
    input  logic               read_en2,
    output logic               read_valid1,
    output logic               read_valid2,
    output logic [31:0]        read_pc1,
    output logic [31:0]        read_inst1,
    output logic [31:0]        read_pc2,
    output logic [31:0]        read_inst2,
    output logic               fifo_full,
    output logic               fifo_empty,
    output logic [PTR_W:0]     count,
    output logic [31:0]        full_cycles
);

    // Full as soon as fewer than two slots are free, so a 2-wide push always fits.
    localparam logic [PTR_W:0] FULL_LIMIT = (PTR_W+1)'(DEPTH - 2);
    localparam logic [31:0]    FC_MAX     = 32'hFFFF_FFFF;

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] head_p1_s, tail_p1_s;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W:0]   n_rd_req_s, n_rd_s, n_wr_s;
    logic [31:0]      fc_q, fc_d;
    logic             full_s;
    logic             wr1_s, wr2_s;
    logic [63:0]      entry1_s, entry2_s;

    assign full_s    = (count_q > FULL_LIMIT);
    assign head_p1_s = head_q + PTR_W'(1);
    assign tail_p1_s = tail_q + PTR_W'(1);

    // Decode pop/push requests; pops clamp to occupancy, pushes need a non-full queue.
    always_comb begin
        n_rd_req_s = (PTR_W+1)'(0);
        n_rd_s     = (PTR_W+1)'(0);
        n_wr_s     = (PTR_W+1)'(0);
        wr1_s      = 1'b0;
        wr2_s      = 1'b0;
        if (read_en1 && read_en2) begin
            n_rd_req_s = (PTR_W+1)'(2);
        end else if (read_en1) begin
            n_rd_req_s = (PTR_W+1)'(1);
        end else begin
            n_rd_req_s = (PTR_W+1)'(0);
        end
        if (n_rd_req_s > count_q) begin
            n_rd_s = count_q;
        end else begin
            n_rd_s = n_rd_req_s;
        end
        wr1_s = write_en1 && !full_s && !flush;
        wr2_s = wr1_s && write_en2;
        if (wr2_s) begin
            n_wr_s = (PTR_W+1)'(2);
        end else if (wr1_s) begin
            n_wr_s = (PTR_W+1)'(1);
        end else begin
            n_wr_s = (PTR_W+1)'(0);
        end
    end

    // Next pointer/count state; flush overrides any same-cycle push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = PTR_W'(0);
            tail_d  = PTR_W'(0);
            count_d = (PTR_W+1)'(0);
        end else begin
            head_d  = head_q + n_rd_s[PTR_W-1:0];
            tail_d  = tail_q + n_wr_s[PTR_W-1:0];
            count_d = count_q + n_wr_s - n_rd_s;
        end
    end

    // Saturating count of cycles spent full; survives flush.
    always_comb begin
        fc_d = fc_q;
        if (full_s && (fc_q != FC_MAX)) begin
            fc_d = fc_q + 32'd1;
        end else begin
            fc_d = fc_q;
        end
    end

    // Pointer, occupancy and perf-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= PTR_W'(0);
            tail_q  <= PTR_W'(0);
            count_q <= (PTR_W+1)'(0);
            fc_q    <= 32'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fc_q    <= fc_d;
        end
    end

    // Entry storage; not reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr1_s) begin
            mem_q[tail_q] <= {write_pc1, write_inst1};
        end
        if (wr2_s) begin
            mem_q[tail_p1_s] <= {write_pc2, write_inst2};
        end
    end

    // First-word-fall-through read ports, zeroed when the slot is empty.
    always_comb begin
        entry1_s    = mem_q[head_q];
        entry2_s    = mem_q[head_p1_s];
        read_valid1 = (count_q != (PTR_W+1)'(0));
        read_valid2 = (count_q >= (PTR_W+1)'(2));
        if (read_valid1) begin
            read_pc1   = entry1_s[63:32];
            read_inst1 = entry1_s[31:0];
        end else begin
            read_pc1   = 32'd0;
            read_inst1 = 32'd0;
        end
        if (read_valid2) begin
            read_pc2   = entry2_s[63:32];
            read_inst2 = entry2_s[31:0];
        end else begin
            read_pc2   = 32'd0;
            read_inst2 = 32'd0;
        end
    end

    assign fifo_full   = full_s;
    assign fifo_empty  = (count_q == (PTR_W+1)'(0));
    assign count       = count_q;
    assign full_cycles = fc_q;

    inst_fifo_checker #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_checker (
        .clk       (clk),
        .rst       (rst),
        .write_en1 (write_en1),
        .write_en2 (write_en2),
        .read_en1  (read_en1),
        .read_en2  (read_en2),
        .count_q   (count_q)
    );

endmodule

// Protocol checks for the queue: illegal enable combinations and occupancy bound.
module inst_fifo_checker #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input logic           clk,
    input logic           rst,
    input logic           write_en1,
    input logic           write_en2,
    input logic           read_en1,
    input logic           read_en2,
    input logic [PTR_W:0] count_q
);

    a_wr2_needs_wr1: assert property (@(posedge clk) disable iff (rst)
        !(write_en2 && !write_en1));

    a_rd2_needs_rd1: assert property (@(posedge clk) disable iff (rst)
        !(read_en2 && !read_en1));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= (PTR_W+1)'(DEPTH));

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: vector table plus queue scoreboard,
// followed by hand-written steady-state, flush and async-reset sequences.
module tb_inst_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush, write_en1, write_en2, read_en1, read_en2;
    logic [31:0] write_pc1, write_inst1, write_pc2, write_inst2;
    logic        read_valid1, read_valid2, fifo_full, fifo_empty;
    logic [31:0] read_pc1, read_inst1, read_pc2, read_inst2, full_cycles;
    logic [4:0]  count;

    inst_fifo #(.DEPTH(DEPTH), .PTR_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .write_en1(write_en1), .write_en2(write_en2),
        .write_pc1(write_pc1), .write_inst1(write_inst1),
        .write_pc2(write_pc2), .write_inst2(write_inst2),
        .read_en1(read_en1), .read_en2(read_en2),
        .read_valid1(read_valid1), .read_valid2(read_valid2),
        .read_pc1(read_pc1), .read_inst1(read_inst1),
        .read_pc2(read_pc2), .read_inst2(read_inst2),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .count(count), .full_cycles(full_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct packed {
        logic       we1;
        logic       we2;
        logic       re1;
        logic       re2;
        logic       fl;
        logic [4:0] cnt;
    } vec_t;

    ent_t        sb[$];
    vec_t        vecs[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] pc_next;
    logic [31:0] fc_m;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Compare all outputs against the scoreboard model state.
    task automatic chk_model(input string tag);
        int n;
        n = sb.size();
        chk({tag, " count"}, 32'(count), 32'(n));
        chk({tag, " empty"}, 32'(fifo_empty), 32'(n == 0));
        chk({tag, " full"}, 32'(fifo_full), 32'(n > DEPTH - 2));
        chk({tag, " valid1"}, 32'(read_valid1), 32'(n >= 1));
        chk({tag, " valid2"}, 32'(read_valid2), 32'(n >= 2));
        chk({tag, " pc1"}, read_pc1, (n >= 1) ? sb[0].pc : 32'd0);
        chk({tag, " inst1"}, read_inst1, (n >= 1) ? sb[0].inst : 32'd0);
        chk({tag, " pc2"}, read_pc2, (n >= 2) ? sb[1].pc : 32'd0);
        chk({tag, " inst2"}, read_inst2, (n >= 2) ? sb[1].inst : 32'd0);
        chk({tag, " full_cycles"}, full_cycles, fc_m);
    endtask

    // One clock of stimulus: called just after a rising edge, returns just after the next.
    task automatic step(input logic we1, input logic we2, input logic re1,
                        input logic re2, input logic fl);
        int   nrd;
        logic full_m;
        write_en1   = we1;
        write_en2   = we2;
        read_en1    = re1;
        read_en2    = re2;
        flush       = fl;
        write_pc1   = pc_next;
        write_inst1 = inst_of(pc_next);
        write_pc2   = pc_next + 32'd4;
        write_inst2 = inst_of(pc_next + 32'd4);
        #1;
        chk_model("pre");
        full_m = (sb.size() > DEPTH - 2);
        nrd    = re1 ? (re2 ? 2 : 1) : 0;
        if (nrd > sb.size()) nrd = sb.size();
        @(posedge clk);
        #1;
        if (full_m && fc_m != 32'hFFFF_FFFF) fc_m = fc_m + 32'd1;
        if (fl) begin
            sb.delete();
        end else begin
            for (int k = 0; k < nrd; k++) void'(sb.pop_front());
            if (!full_m && we1) begin
                sb.push_back('{pc_next, inst_of(pc_next)});
                if (we2) sb.push_back('{pc_next + 32'd4, inst_of(pc_next + 32'd4)});
            end
        end
        pc_next = pc_next + 32'd8;
        chk("post count", 32'(count), 32'(sb.size()));
    endtask

    initial begin
        flush = 1'b0; write_en1 = 1'b0; write_en2 = 1'b0;
        read_en1 = 1'b0; read_en2 = 1'b0;
        write_pc1 = 32'd0; write_inst1 = 32'd0; write_pc2 = 32'd0; write_inst2 = 32'd0;
        fc_m = 32'd0;

        // Vector table: {we1,we2,re1,re2,flush, expected count after the edge}
        vecs.push_back({5'b11000, 5'd2});   // 0  first 2-wide push
        vecs.push_back({5'b00110, 5'd0});   // 1  pop both
        for (int k = 1; k <= 8; k++)
            vecs.push_back({5'b11000, 5'(2 * k)}); // 2..9 fill to 16
        vecs.push_back({5'b11000, 5'd16});  // 10 dropped while full
        vecs.push_back({5'b00000, 5'd16});  // 11 idle full
        vecs.push_back({5'b00110, 5'd14});  // 12
        vecs.push_back({5'b00100, 5'd13});  // 13 single pop
        for (int k = 0; k < 6; k++)
            vecs.push_back({5'b00110, 5'(11 - 2 * k)}); // 14..19 down to 1
        vecs.push_back({5'b00110, 5'd0});   // 20 pop-2 at count 1 pops one
        vecs.push_back({5'b00110, 5'd0});   // 21 pop on empty ignored

        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(fifo_empty), 32'd1);
        chk("reset full", 32'(fifo_full), 32'd0);
        chk("reset valid1", 32'(read_valid1), 32'd0);
        chk("reset pc1", read_pc1, 32'd0);
        chk("reset full_cycles", full_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        pc_next = 32'hBFC0_0000;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].we1, vecs[i].we2, vecs[i].re1, vecs[i].re2, vecs[i].fl);
            chk($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
            if (i == 0) begin
                chk("boot valid2", 32'(read_valid2), 32'd1);
                chk("boot pc1", read_pc1, 32'hBFC0_0000);
                chk("boot pc2", read_pc2, 32'hBFC0_0004);
            end
            if (i == 10) begin
                chk("full flag", 32'(fifo_full), 32'd1);
                chk("full_cycles after drop", full_cycles, 32'd1);
            end
            if (i == 20) begin
                chk("drain empty", 32'(fifo_empty), 32'd1);
                chk("drain valid1", 32'(read_valid1), 32'd0);
                chk("drain pc1", read_pc1, 32'd0);
                chk("drain inst1", read_inst1, 32'd0);
            end
        end

        // Steady state at count 4 across pointer wrap
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            chk("steady count", 32'(count), 32'd4);
        end

        // Flush at count 10 with simultaneous push and pop
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pre-flush count", 32'(count), 32'd10);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("flush count", 32'(count), 32'd0);
        chk("flush empty", 32'(fifo_empty), 32'd1);
        chk("flush valid1", 32'(read_valid1), 32'd0);
        pc_next = 32'h0000_4000;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post-flush pc1", read_pc1, 32'h0000_4000);

        // Asynchronous reset in the middle of a burst
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        write_en1 = 1'b1;
        write_en2 = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async count", 32'(count), 32'd0);
        chk("async empty", 32'(fifo_empty), 32'd1);
        chk("async valid1", 32'(read_valid1), 32'd0);
        chk("async valid2", 32'(read_valid2), 32'd0);
        chk("async pc1", read_pc1, 32'd0);
        chk("async full_cycles", full_cycles, 32'd0);
        #3;
        rst = 1'b0;
        write_en1 = 1'b0;
        write_en2 = 1'b0;
        sb.delete();
        fc_m = 32'd0;
        @(posedge clk);
        #1;
        pc_next = 32'hCAFE_0000;
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("post-reset pc1", read_pc1, 32'hCAFE_0000);
        chk("post-reset pc2", read_pc2, 32'hCAFE_0004);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
